// File: rtl/sys_ctrl_gen2.sv
// rtl/sys_ctrl_gen2.sv - frame-driven register/ALU command controller with back-pressured result push
module sys_ctrl_gen2 #(
   parameter int FRAME_WIDTH         = 8,
   parameter int ALU_DATA_WIDTH      = 16,
   parameter int ALU_FUNC_WIDTH      = 4,
   parameter int REG_FILE_ADDR_WIDTH = 4,
   parameter int OPA_ADDR            = 0,
   parameter int OPB_ADDR            = 1,
   parameter int TIMEOUT_CYCLES      = 255
) (
   input  logic                           CLK,
   input  logic                           RST,
   input  logic [FRAME_WIDTH-1:0]         RX_P_DATA,
   input  logic                           RX_P_VLD,
   input  logic [ALU_DATA_WIDTH-1:0]      ALU_OUT,
   input  logic                           OUT_VALID,
   input  logic [FRAME_WIDTH-1:0]         RdData,
   input  logic                           RdData_Valid,
   input  logic                           FIFO_FULL,
   output logic [ALU_FUNC_WIDTH-1:0]      ALU_FUNC,
   output logic                           ALU_EN,
   output logic                           CLK_EN,
   output logic [REG_FILE_ADDR_WIDTH-1:0] RF_ADDR,
   output logic                           WrEn,
   output logic                           RdEn,
   output logic [FRAME_WIDTH-1:0]         WrData,
   output logic                           WR_INC,
   output logic                           clk_div_en,
   output logic                           CMD_ERR,
   output logic                           BUSY
);

   // Frames per result; the frame counter must be able to hold NUM itself
   localparam int NUM = ALU_DATA_WIDTH / FRAME_WIDTH;
   localparam int CW  = $clog2(NUM + 1);
   // Timeout counter only ever reaches TIMEOUT_CYCLES-1
   localparam int TW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   localparam logic [FRAME_WIDTH-1:0] CMD_WR  = FRAME_WIDTH'('hAA);
   localparam logic [FRAME_WIDTH-1:0] CMD_RD  = FRAME_WIDTH'('hBB);
   localparam logic [FRAME_WIDTH-1:0] CMD_ALU = FRAME_WIDTH'('hCC);
   localparam logic [FRAME_WIDTH-1:0] CMD_FN  = FRAME_WIDTH'('hDD);

   typedef enum logic [3:0] {
      S_IDLE, S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_RD_WAIT,
      S_ALU_A, S_ALU_B, S_ALU_FN, S_ALU_WAIT, S_PUSH
   } state_t;

   state_t                           r_state;
   logic [REG_FILE_ADDR_WIDTH-1:0]   r_addr;
   logic [REG_FILE_ADDR_WIDTH-1:0]   r_rf_addr;
   logic [FRAME_WIDTH-1:0]           r_wr_data;
   logic                             r_wr_en;
   logic                             r_rd_en;
   logic                             r_alu_en;
   logic [ALU_FUNC_WIDTH-1:0]        r_alu_func;
   logic                             r_clk_en;
   logic                             r_cmd_err;
   logic [ALU_DATA_WIDTH-1:0]        r_result;
   logic [CW-1:0]                    r_num;
   logic [CW-1:0]                    r_idx;
   logic [TW-1:0]                    r_tmo_cnt;

   logic w_wait;
   logic w_event;
   logic w_timeout;

   // Which states are waiting on something, and what ends the wait
   always_comb begin
      w_wait  = 1'b0;
      w_event = 1'b0;
      case (r_state)
         S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_ALU_A, S_ALU_B, S_ALU_FN: begin
            w_wait  = 1'b1;
            w_event = RX_P_VLD;
         end
         S_RD_WAIT: begin
            w_wait  = 1'b1;
            w_event = RdData_Valid;
         end
         S_ALU_WAIT: begin
            w_wait  = 1'b1;
            w_event = OUT_VALID;
         end
         default: begin
            w_wait  = 1'b0;
            w_event = 1'b0;
         end
      endcase
   end

   // An arriving event always wins over an expiring timeout
   assign w_timeout = (TIMEOUT_CYCLES != 0) && w_wait && !w_event && (r_tmo_cnt == TMO_LAST);

   // Command sequencing, registered strobes, timeout and result serialisation
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state    <= S_IDLE;
         r_addr     <= '0;
         r_rf_addr  <= '0;
         r_wr_data  <= '0;
         r_wr_en    <= 1'b0;
         r_rd_en    <= 1'b0;
         r_alu_en   <= 1'b0;
         r_alu_func <= '0;
         r_clk_en   <= 1'b0;
         r_cmd_err  <= 1'b0;
         r_result   <= '0;
         r_num      <= '0;
         r_idx      <= '0;
         r_tmo_cnt  <= '0;
      end else begin
         r_wr_en   <= 1'b0;
         r_rd_en   <= 1'b0;
         r_alu_en  <= 1'b0;
         r_cmd_err <= 1'b0;
         if (w_wait && !w_event) begin
            r_tmo_cnt <= r_tmo_cnt + TW'(1);
         end else begin
            r_tmo_cnt <= '0;
         end
         if (w_timeout) begin
            r_state    <= S_IDLE;
            r_cmd_err  <= 1'b1;
            r_clk_en   <= 1'b0;
            r_alu_func <= '0;
            r_tmo_cnt  <= '0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (RX_P_VLD) begin
                     if (RX_P_DATA == CMD_WR) begin
                        r_state <= S_WR_ADDR;
                     end else if (RX_P_DATA == CMD_RD) begin
                        r_state <= S_RD_ADDR;
                     end else if (RX_P_DATA == CMD_ALU) begin
                        r_state <= S_ALU_A;
                     end else if (RX_P_DATA == CMD_FN) begin
                        r_state <= S_ALU_FN;
                     end else begin
                        r_cmd_err <= 1'b1;
                     end
                  end
               end
               S_WR_ADDR: begin
                  if (RX_P_VLD) begin
                     r_addr  <= RX_P_DATA[REG_FILE_ADDR_WIDTH-1:0];
                     r_state <= S_WR_DATA;
                  end
               end
               S_WR_DATA: begin
                  if (RX_P_VLD) begin
                     r_wr_en   <= 1'b1;
                     r_rf_addr <= r_addr;
                     r_wr_data <= RX_P_DATA;
                     r_state   <= S_IDLE;
                  end
               end
               S_RD_ADDR: begin
                  if (RX_P_VLD) begin
                     r_rd_en   <= 1'b1;
                     r_rf_addr <= RX_P_DATA[REG_FILE_ADDR_WIDTH-1:0];
                     r_state   <= S_RD_WAIT;
                  end
               end
               S_RD_WAIT: begin
                  r_cmd_err <= RX_P_VLD;
                  if (RdData_Valid) begin
                     r_result <= ALU_DATA_WIDTH'(RdData);
                     r_num    <= CW'(1);
                     r_idx    <= '0;
                     r_state  <= S_PUSH;
                  end
               end
               S_ALU_A: begin
                  if (RX_P_VLD) begin
                     r_wr_en   <= 1'b1;
                     r_rf_addr <= REG_FILE_ADDR_WIDTH'(OPA_ADDR);
                     r_wr_data <= RX_P_DATA;
                     r_state   <= S_ALU_B;
                  end
               end
               S_ALU_B: begin
                  if (RX_P_VLD) begin
                     r_wr_en   <= 1'b1;
                     r_rf_addr <= REG_FILE_ADDR_WIDTH'(OPB_ADDR);
                     r_wr_data <= RX_P_DATA;
                     r_state   <= S_ALU_FN;
                  end
               end
               S_ALU_FN: begin
                  if (RX_P_VLD) begin
                     r_alu_en   <= 1'b1;
                     r_alu_func <= RX_P_DATA[ALU_FUNC_WIDTH-1:0];
                     r_clk_en   <= 1'b1;
                     r_state    <= S_ALU_WAIT;
                  end
               end
               S_ALU_WAIT: begin
                  r_cmd_err <= RX_P_VLD;
                  if (OUT_VALID) begin
                     r_result <= ALU_OUT;
                     r_num    <= CW'(NUM);
                     r_idx    <= '0;
                     r_clk_en <= 1'b0;
                     r_state  <= S_PUSH;
                  end
               end
               S_PUSH: begin
                  r_cmd_err <= RX_P_VLD;
                  // The result is shifted down so the frame being offered is always the low slice
                  if (!FIFO_FULL) begin
                     r_result <= r_result >> FRAME_WIDTH;
                     if (r_idx == r_num - CW'(1)) begin
                        r_idx      <= '0;
                        r_alu_func <= '0;
                        r_state    <= S_IDLE;
                     end else begin
                        r_idx <= r_idx + CW'(1);
                     end
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign WrEn       = r_wr_en;
   assign RdEn       = r_rd_en;
   assign ALU_EN     = r_alu_en;
   assign ALU_FUNC   = r_alu_func;
   assign CLK_EN     = r_clk_en;
   assign RF_ADDR    = r_rf_addr;
   assign CMD_ERR    = r_cmd_err;
   assign BUSY       = (r_state != S_IDLE);
   assign WR_INC     = (r_state == S_PUSH) && !FIFO_FULL;
   assign WrData     = (r_state == S_PUSH) ? r_result[FRAME_WIDTH-1:0] : r_wr_data;
   assign clk_div_en = 1'b1;

endmodule

// File: tb/tb_sys_ctrl_gen2.sv
// tb/tb_sys_ctrl_gen2.sv - self-checking bench for sys_ctrl_gen2 with behavioural command model
module tb_sys_ctrl_gen2;

   localparam int TMO = 10;
   localparam int DW  = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rst32_n = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        rx_vld = 1'b0;
   logic [31:0] alu_out = '0;
   logic        out_valid = 1'b0;
   logic [7:0]  rd_data = '0;
   logic        rd_vld = 1'b0;
   logic        fifo_full = 1'b0;

   logic [3:0]  alu_func, rf_addr;
   logic        alu_en, clk_en, wr_en, rd_en, wr_inc, div_en, cmd_err, busy;
   logic [7:0]  wr_data;

   logic [3:0]  b_alu_func, b_rf_addr;
   logic        b_alu_en, b_clk_en, b_wr_en, b_rd_en, b_wr_inc, b_div_en, b_cmd_err, b_busy;
   logic [7:0]  b_wr_data;

   int total = 0;
   int bad = 0;
   int n_inc = 0;

   always #5 clk = ~clk;

   sys_ctrl_gen2 #(.ALU_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
      .CLK(clk), .RST(rst_n), .RX_P_DATA(rx_data), .RX_P_VLD(rx_vld),
      .ALU_OUT(alu_out[15:0]), .OUT_VALID(out_valid), .RdData(rd_data), .RdData_Valid(rd_vld),
      .FIFO_FULL(fifo_full), .ALU_FUNC(alu_func), .ALU_EN(alu_en), .CLK_EN(clk_en),
      .RF_ADDR(rf_addr), .WrEn(wr_en), .RdEn(rd_en), .WrData(wr_data), .WR_INC(wr_inc),
      .clk_div_en(div_en), .CMD_ERR(cmd_err), .BUSY(busy));

   sys_ctrl_gen2 #(.ALU_DATA_WIDTH(32)) dut32 (
      .CLK(clk), .RST(rst32_n), .RX_P_DATA(rx_data), .RX_P_VLD(rx_vld),
      .ALU_OUT(alu_out), .OUT_VALID(out_valid), .RdData(rd_data), .RdData_Valid(rd_vld),
      .FIFO_FULL(fifo_full), .ALU_FUNC(b_alu_func), .ALU_EN(b_alu_en), .CLK_EN(b_clk_en),
      .RF_ADDR(b_rf_addr), .WrEn(b_wr_en), .RdEn(b_rd_en), .WrData(b_wr_data), .WR_INC(b_wr_inc),
      .clk_div_en(b_div_en), .CMD_ERR(b_cmd_err), .BUSY(b_busy));

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   // Behavioural model: pending command byte, frames seen, awaited response, queue of frames to push
   int         m_cmd = 0;
   int         m_got = 0;
   int         m_await = 0;
   int         m_idle = 0;
   logic [3:0] m_addr = '0;
   logic [7:0] m_q[$];
   logic       e_wren = 0, e_rden = 0, e_aluen = 0, e_err = 0, e_clken = 0;
   logic [3:0] e_addr = '0, e_func = '0;
   logic [7:0] e_wdata = '0;

   task automatic model_func(input logic [7:0] d);
      e_aluen = 1'b1;
      e_func  = d[3:0];
      e_clken = 1'b1;
      m_cmd   = 0;
      m_await = 2;
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cmd = 0; m_got = 0; m_await = 0; m_idle = 0; m_addr = '0; m_q.delete();
         e_wren = 0; e_rden = 0; e_aluen = 0; e_err = 0; e_clken = 0;
         e_addr = '0; e_func = '0; e_wdata = '0;
      end else begin
         e_wren = 0; e_rden = 0; e_aluen = 0; e_err = 0;
         if (m_q.size() > 0) begin
            if (rx_vld) e_err = 1'b1;
            if (!fifo_full) begin
               void'(m_q.pop_front());
               if (m_q.size() == 0) e_func = '0;
            end
         end else if (m_await != 0) begin
            if (rx_vld) e_err = 1'b1;
            if (m_await == 1 && rd_vld) begin
               m_q.push_back(rd_data);
               m_await = 0;
            end else if (m_await == 2 && out_valid) begin
               for (int k = 0; k < DW / 8; k++) m_q.push_back(alu_out[8*k +: 8]);
               m_await = 0;
               e_clken = 1'b0;
            end else begin
               m_idle++;
               if (m_idle == TMO) begin
                  m_await = 0; m_idle = 0; e_err = 1'b1; e_clken = 1'b0; e_func = '0;
               end
            end
         end else if (m_cmd != 0) begin
            if (rx_vld) begin
               m_idle = 0;
               case (m_cmd)
                  'hAA: begin
                     if (m_got == 0) begin
                        m_addr = rx_data[3:0];
                        m_got  = 1;
                     end else begin
                        e_wren = 1'b1; e_addr = m_addr; e_wdata = rx_data; m_cmd = 0;
                     end
                  end
                  'hBB: begin
                     e_rden = 1'b1; e_addr = rx_data[3:0]; m_cmd = 0; m_await = 1;
                  end
                  'hCC: begin
                     if (m_got < 2) begin
                        e_wren  = 1'b1;
                        e_addr  = (m_got == 0) ? 4'd0 : 4'd1;
                        e_wdata = rx_data;
                        m_got++;
                     end else begin
                        model_func(rx_data);
                     end
                  end
                  default: model_func(rx_data);
               endcase
            end else begin
               m_idle++;
               if (m_idle == TMO) begin
                  m_cmd = 0; m_idle = 0; e_err = 1'b1; e_func = '0;
               end
            end
         end else if (rx_vld) begin
            if (rx_data inside {8'hAA, 8'hBB, 8'hCC, 8'hDD}) begin
               m_cmd = int'(rx_data); m_got = 0; m_idle = 0;
            end else begin
               e_err = 1'b1;
            end
         end
      end
   end

   // Compare the main DUT with the model every cycle, mid-cycle
   always @(negedge clk) begin
      check("WrEn", wr_en, e_wren);
      check("RdEn", rd_en, e_rden);
      check("ALU_EN", alu_en, e_aluen);
      check("CMD_ERR", cmd_err, e_err);
      check("CLK_EN", clk_en, e_clken);
      check("RF_ADDR", rf_addr, e_addr);
      check("ALU_FUNC", alu_func, e_func);
      check("BUSY", busy, (m_cmd != 0) || (m_await != 0) || (m_q.size() > 0));
      check("WR_INC", wr_inc, (m_q.size() > 0) && !fifo_full);
      check("clk_div_en", div_en, 1'b1);
      if (e_wren) check("WrData_rf", wr_data, e_wdata);
      if ((m_q.size() > 0) && !fifo_full) check("WrData_push", wr_data, m_q[0]);
      if (wr_inc) n_inc++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      rx_vld  = 1'b1;
      rx_data = b;
      tick();
      rx_vld  = 1'b0;
   endtask

   initial begin
      int n0;
      int b_cnt;
      logic quiet;

      repeat (3) tick();
      check("rst_WrEn", wr_en, 0);
      check("rst_BUSY", busy, 0);
      check("rst_CMD_ERR", cmd_err, 0);
      check("rst_WR_INC", wr_inc, 0);
      check("rst_clk_div_en", div_en, 1);
      check("rst_RF_ADDR", rf_addr, 0);
      rst_n = 1'b1;
      tick();

      // Register write
      send(8'hAA); send(8'h05); send(8'h3C);
      check("wr_WrEn", wr_en, 1);
      check("wr_RF_ADDR", rf_addr, 4'h5);
      check("wr_WrData", wr_data, 8'h3C);
      check("wr_BUSY", busy, 0);
      tick();
      check("wr_WrEn_off", wr_en, 0);

      // Register read
      send(8'hBB); send(8'h07);
      check("rd_RdEn", rd_en, 1);
      check("rd_RF_ADDR", rf_addr, 4'h7);
      tick();
      rd_data = 8'h5A; rd_vld = 1'b1;
      tick();
      rd_vld = 1'b0;
      check("rd_WR_INC", wr_inc, 1);
      check("rd_WrData", wr_data, 8'h5A);
      tick();
      check("rd_WR_INC_off", wr_inc, 0);
      check("rd_BUSY", busy, 0);

      // ALU with operands
      send(8'hCC); send(8'h12);
      check("alu_WrEn_a", wr_en, 1);
      check("alu_addr_a", rf_addr, 4'h0);
      check("alu_data_a", wr_data, 8'h12);
      send(8'h34);
      check("alu_addr_b", rf_addr, 4'h1);
      check("alu_data_b", wr_data, 8'h34);
      send(8'h02);
      check("alu_ALU_EN", alu_en, 1);
      check("alu_FUNC", alu_func, 4'h2);
      check("alu_CLK_EN", clk_en, 1);
      tick();
      check("alu_ALU_EN_off", alu_en, 0);
      alu_out = 32'h0000ABCD; out_valid = 1'b1;
      tick();
      out_valid = 1'b0;
      check("alu_push0", wr_data, 8'hCD);
      check("alu_push0_inc", wr_inc, 1);
      check("alu_CLK_EN_off", clk_en, 0);
      tick();
      check("alu_push1", wr_data, 8'hAB);
      tick();
      check("alu_done_inc", wr_inc, 0);
      check("alu_done_busy", busy, 0);
      check("alu_done_func", alu_func, 0);

      // Back-pressure during push
      send(8'hDD); send(8'h01);
      tick();
      alu_out = 32'h00001234; out_valid = 1'b1;
      tick();
      out_valid = 1'b0;
      n0 = n_inc;
      check("bp_first", wr_data, 8'h34);
      tick();
      fifo_full = 1'b1;
      repeat (5) begin
         #1;
         check("bp_stall", wr_inc, 0);
         tick();
      end
      fifo_full = 1'b0;
      #1;
      check("bp_second_inc", wr_inc, 1);
      check("bp_second", wr_data, 8'h12);
      tick();
      check("bp_count", n_inc - n0, 2);
      check("bp_busy", busy, 0);

      // Bad command byte
      send(8'h77);
      check("err_pulse", cmd_err, 1);
      check("err_busy", busy, 0);
      tick();
      check("err_off", cmd_err, 0);

      // Timeout after silence
      send(8'hAA);
      for (int k = 1; k < TMO; k++) begin
         tick();
         check("tmo_wait_err", cmd_err, 0);
      end
      tick();
      check("tmo_err", cmd_err, 1);
      check("tmo_busy", busy, 0);
      check("tmo_wren", wr_en, 0);
      tick();

      // Response on the expiring cycle wins over the timeout
      send(8'hBB); send(8'h03);
      repeat (TMO - 1) tick();
      rd_data = 8'hC3; rd_vld = 1'b1;
      tick();
      rd_vld = 1'b0;
      check("race_inc", wr_inc, 1);
      check("race_data", wr_data, 8'hC3);
      check("race_err", cmd_err, 0);
      tick();

      // 32-bit result, reset during the third frame
      rst32_n = 1'b1;
      tick();
      send(8'hDD); send(8'h00);
      check("w32_alu_en", b_alu_en, 1);
      tick();
      alu_out = 32'hDEADBEEF; out_valid = 1'b1;
      tick();
      out_valid = 1'b0;
      check("w32_f0", b_wr_data, 8'hEF);
      check("w32_f0_inc", b_wr_inc, 1);
      tick();
      check("w32_f1", b_wr_data, 8'hBE);
      tick();
      check("w32_f2", b_wr_data, 8'hAD);
      rst32_n = 1'b0;
      #1;
      check("w32_rst_inc", b_wr_inc, 0);
      check("w32_rst_busy", b_busy, 0);
      b_cnt = 0;
      repeat (3) begin
         tick();
         if (b_wr_inc) b_cnt++;
      end
      check("w32_no_more", b_cnt, 0);
      tick();

      // Randomised traffic checked by the model
      for (int c = 0; c < 4000; c++) begin
         quiet     = (c % 200) < 13;
         rx_vld    = !quiet && ($urandom_range(0, 2) == 0);
         case ($urandom_range(0, 5))
            0: rx_data = 8'hAA;
            1: rx_data = 8'hBB;
            2: rx_data = 8'hCC;
            3: rx_data = 8'hDD;
            default: rx_data = 8'($urandom);
         endcase
         rd_vld    = !quiet && ($urandom_range(0, 3) == 0);
         rd_data   = 8'($urandom);
         out_valid = !quiet && ($urandom_range(0, 3) == 0);
         alu_out   = $urandom;
         fifo_full = ($urandom_range(0, 2) == 0);
         rst_n     = ($urandom_range(0, 599) != 0);
         tick();
      end
      rst_n = 1'b1;
      rx_vld = 1'b0; rd_vld = 1'b0; out_valid = 1'b0; fifo_full = 1'b0;
      repeat (3) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
